// File: rtl/sysmem_pkg.sv
// Shared types, lane geometry and the address-window compare for the system BRAM port controller.
package sysmem_pkg;

  localparam int SYSMEM_LANES  = 4;
  localparam int SYSMEM_BYTE_W = 8;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    ACK  = 2'd2
  } sysmem_state_t;

  // Address is inside the window when every bit above the word index matches the base.
  function automatic logic sysmem_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int          addr_w);
    logic [31:0] diff_s;
    diff_s = (addr ^ base) >> (addr_w + 2);
    return (diff_s == 32'd0);
  endfunction

endpackage

// File: rtl/sysmem_port_ctrl_boot_loader.sv
// Boot-image byte loader: byte counter, lane one-hot and end-of-image detect (SYSMEM_BOOTLOAD_EN builds only).
module sysmem_boot_loader
  import sysmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    boot_valid,
  input  logic                    boot_last,
  output logic                    accept,
  output logic                    done,
  output logic [ADDR_W-1:0]       word,
  output logic [SYSMEM_LANES-1:0] lane
);

  logic [ADDR_W+1:0] cnt_r;
  logic              cnt_full_s;

  assign cnt_full_s = &cnt_r;
  assign accept     = en & boot_valid;
  assign word       = cnt_r[ADDR_W+1:2];
  assign lane       = {{(SYSMEM_LANES-1){1'b0}}, 1'b1} << cnt_r[1:0];
  // The last slot of the memory ends the image even without boot_last.
  assign done       = accept & (boot_last | cnt_full_s);

  // Byte counter; saturates at the last slot instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {(ADDR_W+2){1'b0}};
    end else if (accept && !cnt_full_s) begin
      cnt_r <= cnt_r + {{(ADDR_W+1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sysmem_port_ctrl.sv
// picorv32 native-bus port controller for four byte-lane system BRAMs with a one-cycle ready.
// Optional boot loader compiled in with `define SYSMEM_BOOTLOAD_EN.
module sysmem_port_ctrl
  import sysmem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  mem_valid,
  output logic                                  mem_ready,
  input  logic [31:0]                           mem_addr,
  input  logic [31:0]                           mem_wdata,
  input  logic [SYSMEM_LANES-1:0]               mem_wstrb,
  output logic [31:0]                           mem_rdata,
  output logic [ADDR_W-1:0]                     ram_addr,
  output logic [SYSMEM_LANES-1:0]               ram_ce,
  output logic [SYSMEM_LANES-1:0]               ram_we,
  output logic [SYSMEM_LANES*SYSMEM_BYTE_W-1:0] ram_di,
  input  logic [SYSMEM_LANES*SYSMEM_BYTE_W-1:0] ram_do
`ifdef SYSMEM_BOOTLOAD_EN
  ,
  input  logic                                  boot_valid,
  output logic                                  boot_ready,
  input  logic [SYSMEM_BYTE_W-1:0]              boot_data,
  input  logic                                  boot_last,
  output logic                                  boot_active
`endif
);

  localparam sysmem_state_t RST_STATE =
`ifdef SYSMEM_BOOTLOAD_EN
    BOOT;
`else
    IDLE;
`endif

  sysmem_state_t                         state_r;
  sysmem_state_t                         state_nxt_s;
  logic                                  ready_r;
  logic                                  rd_r;
  logic                                  in_win_s;
  logic                                  wr_s;
  logic                                  cpu_acc_s;
  logic                                  boot_acc_s;
  logic                                  boot_done_s;
  logic [ADDR_W-1:0]                     boot_word_s;
  logic [SYSMEM_LANES-1:0]               boot_lane_s;
  logic [SYSMEM_LANES*SYSMEM_BYTE_W-1:0] boot_di_s;

  assign in_win_s  = sysmem_in_window(mem_addr, BASE_ADDR, ADDR_W);
  assign wr_s      = |mem_wstrb;
  assign cpu_acc_s = (state_r == IDLE) && mem_valid && in_win_s;

`ifdef SYSMEM_BOOTLOAD_EN
  logic boot_en_s;

  assign boot_en_s   = (state_r == BOOT);
  assign boot_ready  = boot_en_s;
  assign boot_active = boot_en_s;
  assign boot_di_s   = {SYSMEM_LANES{boot_data}};

  sysmem_boot_loader #(
    .ADDR_W (ADDR_W)
  ) u_boot_loader (
    .clk        (clk),
    .rst        (rst),
    .en         (boot_en_s),
    .boot_valid (boot_valid),
    .boot_last  (boot_last),
    .accept     (boot_acc_s),
    .done       (boot_done_s),
    .word       (boot_word_s),
    .lane       (boot_lane_s)
  );
`else
  // Without the loader BOOT is unreachable; should it ever be entered it falls through to IDLE.
  assign boot_acc_s  = 1'b0;
  assign boot_done_s = 1'b1;
  assign boot_word_s = {ADDR_W{1'b0}};
  assign boot_lane_s = {SYSMEM_LANES{1'b0}};
  assign boot_di_s   = {(SYSMEM_LANES*SYSMEM_BYTE_W){1'b0}};
`endif

  assign mem_ready = ready_r;
  // BRAM output is unregistered, so read data is passed straight through in the ACK cycle.
  assign mem_rdata = (ready_r && rd_r) ? ram_do : 32'd0;

  // Next-state decode for the boot / request / acknowledge sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT: begin
        if (boot_done_s) state_nxt_s = IDLE;
        else             state_nxt_s = BOOT;
      end
      IDLE: begin
        if (cpu_acc_s) state_nxt_s = ACK;
        else           state_nxt_s = IDLE;
      end
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Lane port mux: loader bytes during boot, CPU accesses afterwards, all-zero otherwise.
  always_comb begin
    ram_addr = {ADDR_W{1'b0}};
    ram_ce   = {SYSMEM_LANES{1'b0}};
    ram_we   = {SYSMEM_LANES{1'b0}};
    ram_di   = {(SYSMEM_LANES*SYSMEM_BYTE_W){1'b0}};
    if (boot_acc_s) begin
      ram_addr = boot_word_s;
      ram_ce   = boot_lane_s;
      ram_we   = boot_lane_s;
      ram_di   = boot_di_s;
    end else if (cpu_acc_s) begin
      ram_addr = mem_addr[ADDR_W+1:2];
      if (wr_s) begin
        ram_ce = mem_wstrb;
        ram_we = mem_wstrb;
        ram_di = mem_wdata;
      end else begin
        ram_ce = {SYSMEM_LANES{1'b1}};
        ram_we = {SYSMEM_LANES{1'b0}};
        ram_di = {(SYSMEM_LANES*SYSMEM_BYTE_W){1'b0}};
      end
    end else begin
      ram_addr = {ADDR_W{1'b0}};
      ram_ce   = {SYSMEM_LANES{1'b0}};
      ram_we   = {SYSMEM_LANES{1'b0}};
      ram_di   = {(SYSMEM_LANES*SYSMEM_BYTE_W){1'b0}};
    end
  end

  // State, ready pulse and read-type flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RST_STATE;
      ready_r <= 1'b0;
      rd_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= cpu_acc_s;
      if (cpu_acc_s) rd_r <= ~wr_s;
      else           rd_r <= rd_r;
    end
  end

endmodule

// File: tb/tb_sysmem_port_ctrl.sv
// Scoreboard bench for sysmem_port_ctrl: BRAM model, byte-array reference memory, randomized accesses.
module tb_sysmem_port_ctrl;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;
  localparam int BYTES = 4 * WORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]  ram_ce;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do_r;
`ifdef SYSMEM_BOOTLOAD_EN
  logic        boot_valid;
  logic        boot_ready;
  logic [7:0]  boot_data;
  logic        boot_last;
  logic        boot_active;
  int          bcnt;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_e;
  logic        mon_en   = 1'b0;
  logic        bram_init;
  logic [7:0]  ref_mem [BYTES];
  logic [7:0]  bram [4][WORDS];

  always #5 clk = ~clk;

  sysmem_port_ctrl #(
    .ADDR_W    (AW),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .ram_addr  (ram_addr),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_di    (ram_di),
    .ram_do    (ram_do_r)
`ifdef SYSMEM_BOOTLOAD_EN
    ,
    .boot_valid  (boot_valid),
    .boot_ready  (boot_ready),
    .boot_data   (boot_data),
    .boot_last   (boot_last),
    .boot_active (boot_active)
`endif
  );

  function automatic logic [7:0] init_byte(input int b);
    return 8'((b * 37 + 11) % 256);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Four 1024x8 single-port BRAMs with unregistered output: data appears the cycle after a read enable.
  always @(posedge clk) begin
    if (bram_init) begin
      for (int b = 0; b < BYTES; b++) bram[b % 4][b / 4] <= init_byte(b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ram_ce[i]) begin
          if (ram_we[i]) bram[i][ram_addr] <= ram_di[8*i +: 8];
          else           ram_do_r[8*i +: 8] <= bram[i][ram_addr];
        end
      end
    end
  end

  // Monitor: every ready pulse must match the oldest expected response; rdata is zero otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready actual=1 required=0");
        end else begin
          exp_e = exp_q.pop_front();
          chk("rdata", mem_rdata, exp_e);
        end
      end else begin
        chk("rdata_idle_zero", mem_rdata, 32'd0);
      end
    end
  end

  // In-window access; leaves mem_valid high through ACK and returns one edge later (posedge + 1).
  task automatic cpu_acc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int          w;
    logic [31:0] e;
    w = (a % BYTES) / 4;
    e = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (ws == 4'd0)  e[8*i +: 8] = ref_mem[4*w + i];
      else if (ws[i]) ref_mem[4*w + i] = wd[8*i +: 8];
    end
    exp_q.push_back(e);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    @(negedge clk);
    chk("req_addr", 32'(ram_addr), 32'(w));
    chk("req_ce", 32'(ram_ce), (ws == 4'd0) ? 32'hF : 32'(ws));
    chk("req_we", 32'(ram_we), 32'(ws));
    chk("req_di", ram_di, (ws == 4'd0) ? 32'd0 : wd);
    chk("req_ready_low", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_ready", 32'(mem_ready), 32'd1);
    chk("ack_no_access", 32'(ram_ce), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ow_acc(input logic [31:0] a, input int n);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = $urandom;
    mem_wstrb = 4'($urandom_range(0, 15));
    repeat (n) begin
      @(negedge clk);
      chk("ow_ce", 32'(ram_ce), 32'd0);
      chk("ow_ready", 32'(mem_ready), 32'd0);
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
  endtask

`ifdef SYSMEM_BOOTLOAD_EN
  task automatic boot_byte(input logic [7:0] d, input logic last);
    boot_valid = 1'b1;
    boot_data  = d;
    boot_last  = last;
    ref_mem[bcnt] = d;
    @(negedge clk);
    chk("boot_ce", 32'(ram_ce), 32'(1 << (bcnt % 4)));
    chk("boot_we", 32'(ram_we), 32'(1 << (bcnt % 4)));
    chk("boot_addr", 32'(ram_addr), 32'(bcnt / 4));
    chk("boot_di", ram_di, {d, d, d, d});
    chk("boot_active_hi", 32'(boot_active), 32'd1);
    chk("boot_no_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    bcnt++;
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    bram_init = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
`ifdef SYSMEM_BOOTLOAD_EN
    boot_valid = 1'b0;
    boot_data  = 8'd0;
    boot_last  = 1'b0;
    bcnt       = 0;
`endif
    for (int b = 0; b < BYTES; b++) ref_mem[b] = init_byte(b);
    repeat (2) @(posedge clk);
    #1;
    bram_init = 1'b0;
    rst       = 1'b0;
    mon_en    = 1'b1;

    @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_ce", 32'(ram_ce), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_di", ram_di, 32'd0);
`ifdef SYSMEM_BOOTLOAD_EN
    chk("rst_boot_active", 32'(boot_active), 32'd1);
    chk("rst_boot_ready", 32'(boot_ready), 32'd1);
`endif
    @(posedge clk); #1;

`ifdef SYSMEM_BOOTLOAD_EN
    // CPU read of word 1 is posted before the image arrives and must stall until boot ends.
    exp_q.push_back(32'h8877_6655);
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0004;
    mem_wstrb = 4'd0;
    repeat (2) begin
      @(negedge clk);
      chk("boot_stall_ce", 32'(ram_ce), 32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) boot_byte(8'(8'h11 * (k + 1)), (k == 7));
    @(negedge clk);
    chk("boot_exit", 32'(boot_active), 32'd0);
    chk("boot_first_req_ce", 32'(ram_ce), 32'hF);
    chk("boot_first_req_addr", 32'(ram_addr), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("boot_first_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    idle(1);
    cpu_acc(32'h0000_0000, 32'd0, 4'd0);
    idle(1);
`endif

    // Directed: full word, single byte lane, read-back.
    cpu_acc(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    idle(1);
    cpu_acc(32'h0000_0010, 32'h00AA_0000, 4'b0100);
    idle(1);
    cpu_acc(32'h0000_0010, 32'd0, 4'd0);
    idle(2);

    // Back-to-back at the minimum two-cycle period with mem_valid held through ACK.
    cpu_acc(32'h0000_0020, 32'h1234_5678, 4'b1111);
    cpu_acc(32'h0000_0020, 32'd0, 4'd0);
    cpu_acc(32'h0000_0FFC, 32'hCAFE_F00D, 4'b1001);
    cpu_acc(32'h0000_0FFC, 32'd0, 4'd0);
    idle(1);

    // Out-of-window: just past the window, then random far addresses.
    ow_acc(32'h0000_1000, 10);
    for (int k = 0; k < 4; k++)
      ow_acc((32'($urandom_range(1, 1000)) << 12) | 32'($urandom_range(0, 1023) * 4), 3);
    idle(1);

    // Randomized traffic over a small hot region plus the whole window.
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      logic [3:0]  ws;
      int          gap;
      if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15) * 4);
      else                           a = 32'($urandom_range(0, WORDS - 1) * 4);
      if ($urandom_range(0, 2) == 0) ws = 4'd0;
      else                           ws = 4'($urandom_range(1, 15));
      cpu_acc(a, $urandom, ws);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end
    idle(1);

    // Reset during the ACK cycle: that pulse completes, nothing follows, state returns to reset.
    cpu_acc(32'h0000_0040, 32'h0BAD_CAFE, 4'b1111);
    idle(1);
    exp_q.push_back(32'h0BAD_CAFE);
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0040;
    mem_wstrb = 4'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rst_ack_ready_dropped", 32'(mem_ready), 32'd0);
`ifdef SYSMEM_BOOTLOAD_EN
    chk("rst_ack_boot", 32'(boot_active), 32'd1);
    @(posedge clk); #1;
    bcnt = 0;
    boot_byte(8'h5A, 1'b1);
`else
    @(posedge clk); #1;
`endif
    cpu_acc(32'h0000_0000, 32'd0, 4'd0);
    idle(1);

    // Reset in the cycle a read is presented: no ready may follow.
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0014;
    mem_wstrb = 4'd0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_no_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
`ifdef SYSMEM_BOOTLOAD_EN
    // Full-memory image without boot_last: the loader must stop on the last slot by itself.
    bcnt = 0;
    for (int k = 0; k < BYTES; k++) boot_byte(8'($urandom), 1'b0);
    @(negedge clk);
    chk("boot_full_exit", 32'(boot_active), 32'd0);
    @(posedge clk); #1;
`endif
    for (int k = 0; k < 6; k++) begin
      cpu_acc(32'($urandom_range(0, WORDS - 1) * 4), 32'd0, 4'd0);
      idle(1);
    end
    cpu_acc(32'h0000_0014, 32'd0, 4'd0);
    idle(3);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysmem_port_ctrl.md
# sysmem_port_ctrl

Memory-port controller that drives the four byte-lane single-port system BRAMs (`sysmem_*`, 1024×8 each, unregistered output) from the picorv32 native memory interface. It decodes the CPU's address window and generates per-lane `addra`/`cea`/`wea`/`dia`. It returns read data with a one-cycle `mem_ready` handshake. Optionally it fills the BRAMs from a byte stream after reset, before the CPU runs.

## Interface
- `ADDR_W`, 10: word-address width per lane; depth is 2^ADDR_W words.
- `BASE_ADDR`, 32'h0000_0000: window base, aligned to 4·2^ADDR_W bytes.

Ports:
- `clk` in 1: single clock; the BRAM `clka` is driven from this clock.
- `rst` in 1: synchronous, active-high reset.
- `mem_valid` in 1: CPU request.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte enables; 0 means read.
- `mem_rdata` out 32: read data; 0 whenever `mem_ready`=0.
- `ram_addr` out ADDR_W: shared lane address.
- `ram_ce` out 4: per-lane chip enable.
- `ram_we` out 4: per-lane write enable.
- `ram_di` out 32: lane write data; lane i uses bits [8i+7:8i].
- `ram_do` in 32: lane read data.
- `boot_valid` in 1: loader byte valid (macro only).
- `boot_ready` out 1: loader byte accept (macro only).
- `boot_data` in 8: loader byte (macro only).
- `boot_last` in 1: final byte of the image (macro only).
- `boot_active` out 1: high while loading; the CPU is held in reset externally (macro only).

## Operation
- States: BOOT (macro only), IDLE, ACK.
- Reset state is BOOT with the macro, IDLE without it.
- In-window test: `mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]`. Word index is `mem_addr[ADDR_W+1:2]`.
- IDLE with `mem_valid` and in-window write (wstrb≠0):
  - `ram_addr`=index, `ram_ce`=`ram_we`=wstrb, `ram_di`=wdata, all combinational in the same cycle.
  - Next state ACK.
- IDLE with `mem_valid` and in-window read:
  - `ram_ce`=4'b1111, `ram_we`=0.
  - A read-type flag is registered; next state ACK.
- IDLE with an out-of-window address: no RAM access, stay in IDLE, `mem_ready` is never raised (another slave owns the address).
- ACK:
  - `mem_ready`=1 for exactly one cycle.
  - For reads, `mem_rdata`=`ram_do`; for writes, `mem_rdata`=0.
  - `mem_valid` is ignored in this cycle; the CPU drops it afterwards.
  - Next state IDLE.
- Whenever no access is in progress, `ram_ce`, `ram_we`, `ram_addr` and `ram_di` are all 0.
- BOOT:
  - `boot_ready`=1 and `boot_active`=1.
  - Byte counter `cnt` has width ADDR_W+2 and resets to 0.
  - On accept: `ram_addr`=cnt[ADDR_W+1:2], `ram_ce`=`ram_we`=onehot(cnt[1:0]), `ram_di`={4{boot_data}}; then cnt++.
  - Image is little-endian: byte k lands in lane k mod 4.
  - Exit to IDLE after accepting a byte with `boot_last`=1, or after accepting the byte at cnt = all-ones (full memory). The counter never wraps.
  - CPU requests during BOOT get no RAM access and no `mem_ready`.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `ram_ce`=`ram_we`=0, `ram_addr`=0, `ram_di`=0.
- Reset values with the macro: `boot_ready`=1 and `boot_active`=1 from the first cycle after reset.
- Reset values without the macro: state IDLE.
- Request accepted in cycle N → `mem_ready` in N+1, for reads and writes alike. The read latency matches the BRAM's NOREG output.
- Earliest next request is accepted at N+2, so the minimum period is 2 cycles per access.
- `boot_active` falls in the cycle after the terminating byte is accepted. The first CPU request can be accepted in that same cycle.
- Reset asserted mid-transaction: the pending `mem_ready` is dropped, state returns to the reset state and `cnt`=0. Partial RAM writes are not undone.

## Configuration
- `SYSMEM_BOOTLOAD_EN` defined: BOOT state, `cnt` and the `boot_*` ports are present.
- `SYSMEM_BOOTLOAD_EN` undefined: the `boot_*` ports do not exist, reset goes to IDLE, and the BRAM contents come only from their INIT values.

## Structure
- Shared package `sysmem_pkg` holds:
  - state enum `sysmem_state_t` (BOOT, IDLE, ACK);
  - `SYSMEM_LANES`=4 and `SYSMEM_BYTE_W`=8;
  - the in-window compare as a function.
- One sub-module, `sysmem_boot_loader`: byte counter, lane one-hot and termination detect. It is instantiated only under the macro.
- The top-level port mux selects between loader and CPU signals.

## Test plan
- Full-word write: `mem_addr`=0x10, wdata=0xDEADBEEF, wstrb=4'b1111 at cycle N.
  - Cycle N: `ram_addr`=4, `ram_ce`=`ram_we`=4'b1111.
  - N+1: `mem_ready`=1.
- Byte write then read: wstrb=4'b0100, wdata=0x00AA0000 to 0x10, then read 0x10.
  - Read returns 0xDEAABEEF with `mem_ready` exactly one cycle after the request.
- Out-of-window access at 0x0000_1000 (ADDR_W=10): `ram_ce` stays 0 and `mem_ready` stays 0 for 10 cycles.
- `mem_valid` held high through ACK: no second access in the ACK cycle. Reassertion at N+2 gives `mem_ready` at N+3.
- Boot: bytes 0x11…0x88, with `boot_last` on the 8th byte.
  - Word0=0x44332211, word1=0x88776655.
  - `boot_active` is 0 one cycle later.
  - A CPU read issued during the boot is stalled, then completes after boot with the loaded data.
- Reset mid-read (rst high in cycle N, request accepted in N-1): `mem_ready`=0 at N+1, state IDLE/BOOT, `cnt`=0.
